// File: rtl/weight_bram_loader.sv
// Streams 32-bit beats into a 5*MAC_NUM-bit line buffer and writes one BRAM line per
// filled buffer, starting at a captured base address for a captured number of lines.
module weight_bram_loader #(
  parameter int MAC_NUM            = 256,
  parameter int BRAM_ADDRESS_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] load_base_addr,
  input  logic [BRAM_ADDRESS_WIDTH:0]   load_line_count,
  input  logic                          load_abort,
  input  logic [31:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          bram_wr_en,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_wr_addr,
  output logic [5*MAC_NUM-1:0]          bram_wr_data,
  output logic                          busy,
  output logic                          load_done
);

  localparam int LINE_W = 5 * MAC_NUM;
  localparam int WORDS  = (LINE_W + 31) / 32;
  localparam int WC_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int AW     = BRAM_ADDRESS_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW:0]       lines_left_q, lines_left_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [LINE_W-1:0] line_q, line_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lines_left_q <= '0;
      word_cnt_q   <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lines_left_q <= lines_left_d;
      word_cnt_q   <= word_cnt_d;
      line_q       <= line_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lines_left_d = lines_left_q;
    word_cnt_d   = word_cnt_q;
    line_d       = line_q;
    s_ready      = 1'b0;
    bram_wr_en   = 1'b0;
    load_done    = 1'b0;

    if (load_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start) begin
            addr_d       = load_base_addr;
            lines_left_d = load_line_count;
            word_cnt_d   = '0;
            state_d      = (load_line_count == '0) ? DONE : FILL;
          end
        end
        FILL: begin
          s_ready = 1'b1;
          if (s_valid) begin
            // Bits of the final beat that fall at or above LINE_W are simply never stored.
            for (int i = 0; i < LINE_W; i++) begin
              if (i / 32 == int'(word_cnt_q)) line_d[i] = s_data[i % 32];
            end
            if (word_cnt_q == WC_W'(WORDS - 1)) begin
              word_cnt_d = '0;
              state_d    = WRITE;
            end else begin
              word_cnt_d = word_cnt_q + WC_W'(1);
            end
          end
        end
        WRITE: begin
          bram_wr_en   = 1'b1;
          addr_d       = addr_q + AW'(1);
          lines_left_d = lines_left_q - (AW + 1)'(1);
          state_d      = (lines_left_q == (AW + 1)'(1)) ? DONE : FILL;
        end
        DONE: begin
          load_done = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign bram_wr_addr = addr_q;
  assign bram_wr_data = line_q;

endmodule
